pitch_gain_compute: RTL and testbench
=====================================

Name: pitch_gain_compute

Overview:
- Downstream of the convolution stage in the G.729 adaptive-codebook path.
- Reads the target vector xn and the filtered excitation y1 (the convolution output) from the shared 32-bit memory, one 40-sample subframe each.
- Accumulates the energy yy = <y1,y1> and the correlation xy = <xn,y1>, then computes the pitch gain g = xy/yy in Q14, clamped to [0, 1.2].
- Outputs gain, yy and xy for the gain quantizer.

Parameters:
L_SUBFR, 40, samples per subframe (index i is 6 bits)
GAIN_MAX, 19661, gain clamp in Q14 (1.2)
ACC_W, 40, accumulator width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  begin computation; sampled only in IDLE
xnAddr  input  12  base address of xn; sample i at {xnAddr[11:6], i[5:0]}
y1Addr  input  12  base address of y1; sample i at {y1Addr[11:6], i[5:0]}
memIn  input  32  memory read data; valid the cycle after address; sample = memIn[15:0], signed
memReadAddr  output  12  memory read address
done  output  1  result valid; level, held until next accepted start
gain  output  16  pitch gain, Q14, range 0..GAIN_MAX
yyOut  output  32  energy, saturated to signed 32
xyOut  output  32  correlation, saturated to signed 32

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low, on ports clk and reset.
- Reset (reset==0 at a rising edge), including mid-operation:
  - state returns to IDLE;
  - done, gain, yyOut, xyOut, memReadAddr and the sample index are all cleared to 0;
  - accumulators are cleared.
- States: IDLE, ADDR_X, ADDR_Y, MAC, CHECK, DIVIDE, DONE.
- IDLE/DONE, on start=1:
  - clear done;
  - set yy acc to 1 and xy acc to 0;
  - set i to 0;
  - go to ADDR_X.
- start is ignored in all other states.
- ADDR_X: memReadAddr = xn(i).
- ADDR_Y: memReadAddr = y1(i); latch x = memIn[15:0].
- MAC: latch y = memIn[15:0], then:
  - yy += 2*y*y and xy += 2*x*y, using full-precision signed products in 40-bit accumulators (no saturation is needed);
  - if i==39, go to CHECK; otherwise i+1 and go to ADDR_X.
- Sample cadence: 3 cycles per sample, 120 cycles total.
- CHECK:
  - yyOut and xyOut take their accumulators saturated to [0x80000000, 0x7FFFFFFF];
  - if xy <= 0: gain = 0, go to DONE;
  - if xy >= 2*yy: gain = GAIN_MAX, go to DONE;
  - otherwise go to DIVIDE.
- DIVIDE: restoring division of (xy << 14) by yy (yy > 0 always).
  - 16 cycles, one quotient bit per cycle, MSB first.
  - On the last cycle, gain = min(q, GAIN_MAX), go to DONE.
- DONE: done=1; outputs stable until the next accepted start or reset.
- Latency, counting the start edge as k:
  - done is high after edge k+121 on the zero/clamp path;
  - done is high after edge k+137 on the divide path.
- memReadAddr holds its last value outside the ADDR states.
- Index i wraps only via the terminal check; addresses never carry into base bits [11:6].

Test Plan:
1. y1=0 and xn=1234 for all 40 samples -> yyOut=1, xyOut=0, gain=0, done at start+121.
2. xn=y1=4096 for all samples -> yyOut=1342177281, xyOut=1342177280, gain=16383, done at start+137.
3. y1=1000, xn=2000 -> yyOut=80000001, xyOut=160000000, divide path, gain clamps to 19661.
4. y1=1000, xn=-1000 -> xyOut=-80000000 (0xFB3B4C00), gain=0, zero path.
5. xn=y1=-32768 for all samples -> yyOut=0x7FFFFFFF, xyOut=0x7FFFFFFF (saturated), gain=16383.
6. Start pulse at sample 20, then a second start during MAC -> the second start is ignored. Then reset=0 for 1 cycle mid-run -> all outputs 0 and state IDLE. A fresh start on scenario-2 data then reproduces the scenario-2 results.

Source files
------------

// File: rtl/pitch_gain_compute.sv
// pitch_gain_compute: adaptive-codebook pitch gain for one 40-sample subframe.
// Reads xn and y1 from a shared memory, accumulates yy = 1 + 2*sum(y*y) and
// xy = 2*sum(x*y), then produces g = xy/yy in Q14 clamped to [0, GAIN_MAX].
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   start        begin a subframe (accepted only in IDLE or DONE)
//   xnAddr       base of xn; sample i at {xnAddr[11:6], i}
//   y1Addr       base of y1; sample i at {y1Addr[11:6], i}
//   memIn        read data, valid the cycle after memReadAddr; sample = memIn[15:0]
//   memReadAddr  registered read address
//   done         result valid, held until the next accepted start
//   gain         Q14 pitch gain
//   yyOut/xyOut  accumulators saturated to signed 32 bits
module pitch_gain_compute #(
    parameter int unsigned L_SUBFR  = 40,
    parameter int unsigned GAIN_MAX = 19661,
    parameter int unsigned ACC_W    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] xnAddr,
    input  logic [11:0] y1Addr,
    input  logic [31:0] memIn,
    output logic [11:0] memReadAddr,
    output logic        done,
    output logic [15:0] gain,
    output logic [31:0] yyOut,
    output logic [31:0] xyOut
);

    localparam logic [5:0] LastIdx = 6'(L_SUBFR - 1);
    localparam logic [15:0] GainMax = 16'(GAIN_MAX);

    typedef enum logic [2:0] {
        StIdle, StAddrX, StAddrY, StMac, StCheck, StDivide, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [5:0]               idx_q, idx_d;
    logic [5:0]               xn_base_q, xn_base_d;
    logic [5:0]               y1_base_q, y1_base_d;
    logic signed [15:0]       x_q, x_d;
    logic signed [ACC_W-1:0]  yy_q, yy_d;
    logic signed [ACC_W-1:0]  xy_q, xy_d;
    logic [ACC_W-1:0]         rem_q, rem_d;
    logic [15:0]              dvd_q, dvd_d;
    logic [15:0]              quo_q, quo_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [11:0]              addr_q, addr_d;
    logic                     done_q, done_d;
    logic [15:0]              gain_q, gain_d;
    logic [31:0]              yy_out_q, yy_out_d;
    logic [31:0]              xy_out_q, xy_out_d;

    logic signed [15:0]       sample_s;
    logic signed [31:0]       yy_prod, xy_prod;
    logic signed [ACC_W-1:0]  yy_term, xy_term;
    logic [ACC_W:0]           trial;
    logic                     q_bit;
    logic [15:0]              q_full;
    logic                     unused_bits;

    assign sample_s    = memIn[15:0];
    assign unused_bits = ^{memIn[31:16], xnAddr[5:0], y1Addr[5:0]};

    function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-32:0] top;
        top = v[ACC_W-1:31];
        if ((&top) || (~|top)) return v[31:0];
        else if (v[ACC_W-1]) return 32'h8000_0000;
        else return 32'h7FFF_FFFF;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xn_base_d = xn_base_q;
        y1_base_d = y1_base_q;
        x_d       = x_q;
        yy_d      = yy_q;
        xy_d      = xy_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        done_d    = done_q;
        gain_d    = gain_q;
        yy_out_d  = yy_out_q;
        xy_out_d  = xy_out_q;

        // 16x16 products, sign-extended and doubled; 2*(-32768)^2 needs 33 bits.
        yy_prod = sample_s * sample_s;
        xy_prod = x_q * sample_s;
        yy_term = {{(ACC_W-32){yy_prod[31]}}, yy_prod} <<< 1;
        xy_term = {{(ACC_W-32){xy_prod[31]}}, xy_prod} <<< 1;

        // Restoring-division step: shift in next dividend bit, subtract if it fits.
        trial  = {rem_q, dvd_q[15]};
        q_bit  = (trial >= {1'b0, yy_q});
        q_full = {quo_q[14:0], q_bit};

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    done_d    = 1'b0;
                    yy_d      = ACC_W'(1);
                    xy_d      = '0;
                    idx_d     = '0;
                    xn_base_d = xnAddr[11:6];
                    y1_base_d = y1Addr[11:6];
                    addr_d    = {xnAddr[11:6], 6'd0};
                    state_d   = StAddrX;
                end
            end
            StAddrX: begin
                addr_d  = {y1_base_q, idx_q};
                state_d = StAddrY;
            end
            StAddrY: begin
                x_d     = sample_s;
                state_d = StMac;
            end
            StMac: begin
                yy_d = yy_q + yy_term;
                xy_d = xy_q + xy_term;
                if (idx_q == LastIdx) begin
                    state_d = StCheck;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    addr_d  = {xn_base_q, idx_q + 6'd1};
                    state_d = StAddrX;
                end
            end
            StCheck: begin
                yy_out_d = sat32(yy_q);
                xy_out_d = sat32(xy_q);
                if (xy_q[ACC_W-1] || (xy_q == '0)) begin
                    gain_d  = '0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if ({1'b0, xy_q} >= {yy_q, 1'b0}) begin
                    gain_d  = GainMax;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    // Dividend is xy<<14; xy < 2*yy guarantees (xy>>2) < yy,
                    // so 16 quotient bits suffice.
                    rem_d     = ACC_W'(xy_q >>> 2);
                    dvd_d     = {xy_q[1:0], 14'd0};
                    quo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StDivide;
                end
            end
            StDivide: begin
                rem_d     = q_bit ? ACC_W'(trial - {1'b0, yy_q}) : trial[ACC_W-1:0];
                dvd_d     = {dvd_q[14:0], 1'b0};
                quo_d     = q_full;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    gain_d  = (q_full > GainMax) ? GainMax : q_full;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            xn_base_q <= '0;
            y1_base_q <= '0;
            x_q       <= '0;
            yy_q      <= '0;
            xy_q      <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            gain_q    <= '0;
            yy_out_q  <= '0;
            xy_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xn_base_q <= xn_base_d;
            y1_base_q <= y1_base_d;
            x_q       <= x_d;
            yy_q      <= yy_d;
            xy_q      <= xy_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            gain_q    <= gain_d;
            yy_out_q  <= yy_out_d;
            xy_out_q  <= xy_out_d;
        end
    end

    assign memReadAddr = addr_q;
    assign done        = done_q;
    assign gain        = gain_q;
    assign yyOut       = yy_out_q;
    assign xyOut       = xy_out_q;

endmodule

// File: tb/tb_pitch_gain_compute.sv
// Directed bench for pitch_gain_compute: constant-valued subframes with
// hand-computed energy, correlation, gain and done latency.
module tb_pitch_gain_compute;

    localparam logic [11:0] XnBase = 12'h255;  // low 6 bits must be ignored
    localparam logic [11:0] Y1Base = 12'h5AB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] xnAddr = XnBase;
    logic [11:0] y1Addr = Y1Base;
    logic [31:0] memIn;
    logic [11:0] memReadAddr;
    logic        done;
    logic [15:0] gain;
    logic [31:0] yyOut;
    logic [31:0] xyOut;

    logic [31:0] mem [4096];

    int n_checks = 0;
    int n_errors = 0;

    pitch_gain_compute dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .xnAddr      (xnAddr),
        .y1Addr      (y1Addr),
        .memIn       (memIn),
        .memReadAddr (memReadAddr),
        .done        (done),
        .gain        (gain),
        .yyOut       (yyOut),
        .xyOut       (xyOut)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after the address.
    always @(posedge clk) memIn <= mem[memReadAddr];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] xv, input logic [15:0] yv);
        for (int i = 0; i < 40; i++) begin
            mem[{XnBase[11:6], 6'(i)}] = {16'hDEAD, xv};
            mem[{Y1Base[11:6], 6'(i)}] = {16'hBEEF, yv};
        end
    endtask

    // Start a subframe, optionally re-pulse start at edge k+extra_at, and
    // check latency and results.
    task automatic run_case(input string tag, input logic [31:0] exp_yy,
                            input logic [31:0] exp_xy, input logic [15:0] exp_gain,
                            input int exp_lat, input int extra_at);
        int lat;
        logic [15:0] g_snap;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 300 && lat < 0; n++) begin
            @(negedge clk);
            start = (n == extra_at);
            @(posedge clk);
            #1;
            if (done) lat = n;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_yy"}, 64'(yyOut), 64'(exp_yy));
        check_eq({tag, "_xy"}, 64'(xyOut), 64'(exp_xy));
        check_eq({tag, "_gain"}, 64'(gain), 64'(exp_gain));
        g_snap = gain;
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_done_held"}, 64'(done), 64'd1);
        check_eq({tag, "_gain_held"}, 64'(gain), 64'(g_snap));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = {16'h1357, 16'(a * 37 + 11)};

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_gain", 64'(gain), 64'd0);
        check_eq("rst_yy", 64'(yyOut), 64'd0);
        check_eq("rst_xy", 64'(xyOut), 64'd0);
        check_eq("rst_addr", 64'(memReadAddr), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        load(16'd1234, 16'd0);
        run_case("s1_zero_y", 32'd1, 32'd0, 16'd0, 121, 0);

        load(16'd4096, 16'd4096);
        run_case("s2_equal", 32'd1342177281, 32'd1342177280, 16'd16383, 137, 0);

        load(16'd2000, 16'd1000);
        run_case("s3_clamp", 32'd80000001, 32'd160000000, 16'd19661, 137, 0);

        load(16'hFC18, 16'd1000);  // xn = -1000
        run_case("s4_neg", 32'd80000001, 32'hFB3B4C00, 16'd0, 121, 0);

        load(16'h8000, 16'h8000);  // -32768 both
        run_case("s5_sat", 32'h7FFFFFFF, 32'h7FFFFFFF, 16'd16383, 137, 0);

        // Second start at edge k+60 lands in MAC and must not restart.
        load(16'd4096, 16'd4096);
        run_case("s6_restart", 32'd1342177281, 32'd1342177280, 16'd16383, 137, 60);

        // Mid-run reset.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_gain", 64'(gain), 64'd0);
        check_eq("midrst_yy", 64'(yyOut), 64'd0);
        check_eq("midrst_xy", 64'(xyOut), 64'd0);
        check_eq("midrst_addr", 64'(memReadAddr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_done", 64'(done), 64'd0);
        check_eq("idle_addr", 64'(memReadAddr), 64'd0);

        run_case("s6_fresh", 32'd1342177281, 32'd1342177280, 16'd16383, 137, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
